// File: rtl/neural_stage_collect_if.sv
// Handshake bundle between the neural stage result stream, the frame collector and its consumer.
// The slave modport is the collector's view; the master modport is the producer/consumer side.
interface neural_stage_collect_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             in_valid;
    logic             in_first;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [IW-1:0]    out_index;
    logic             out_last;

    modport slave (
        input  in_valid, in_first, in_data, out_ready,
        output out_valid, out_data, out_index, out_last
    );

    modport master (
        output in_valid, in_first, in_data, out_ready,
        input  out_valid, out_data, out_index, out_last
    );
endinterface

// File: rtl/neural_stage_collect.sv
// Ping-pong frame collector for neural stage results: gathers DEPTH-word frames with an
// optional sign clamp on write, then drains whole frames in completion order.
module neural_stage_collect #(
    parameter int DEPTH   = 16,
    parameter int RELU_EN = 1,
    parameter int WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    neural_stage_collect_if.slave bus,
    output logic                  overflow,
    output logic                  frame_err
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
    localparam logic [IW-1:0] ONE  = IW'(1);

    typedef enum logic [1:0] {IDLE, FILL, DROP} wr_state_t;
    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL} bank_state_t;

    logic [WIDTH-1:0] mem [2][DEPTH];

    wr_state_t   state, state_n;
    bank_state_t bank_st [2];
    bank_state_t bank_n  [2];
    logic [IW-1:0] wp, wp_n, rp, rp_n;
    logic          wb, wb_n, ob, ob_n;

    logic             wr_en;
    logic             wr_bank;
    logic [IW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             ovf_set, ferr_set;
    logic             start, xfer, free_ok, free_sel, nxt_valid;

    always_comb begin
        xfer    = bus.out_valid & bus.out_ready;
        start   = bus.in_valid & bus.in_first;
        wr_data = (RELU_EN != 0 && bus.in_data[WIDTH-1]) ? '0 : bus.in_data;

        // New frames take the oldest slot when free so completion order equals drain order
        free_sel = ob;
        free_ok  = 1'b1;
        if (bank_st[ob] != B_EMPTY) begin
            free_sel = ~ob;
            free_ok  = (bank_st[~ob] == B_EMPTY);
        end

        bank_n[0] = bank_st[0];
        bank_n[1] = bank_st[1];
        state_n   = state;
        wp_n      = wp;
        wb_n      = wb;
        ob_n      = ob;
        rp_n      = rp;
        wr_en     = 1'b0;
        wr_bank   = wb;
        wr_addr   = wp;
        ovf_set   = 1'b0;
        ferr_set  = 1'b0;

        if (xfer) begin
            if (rp == LAST) begin
                bank_n[ob] = B_EMPTY;
                ob_n       = ~ob;
                rp_n       = '0;
            end else begin
                rp_n = rp + ONE;
            end
        end

        case (state)
            FILL: begin
                if (bus.in_valid) begin
                    wr_en = 1'b1;
                    if (bus.in_first) begin
                        // Truncated frame: the discarded bank is always the next to complete,
                        // so the restart reuses it in place rather than searching again.
                        ferr_set = 1'b1;
                        wr_addr  = '0;
                        wp_n     = ONE;
                    end else if (wp == LAST) begin
                        bank_n[wb] = B_FULL;
                        wp_n       = '0;
                        state_n    = IDLE;
                    end else begin
                        wp_n = wp + ONE;
                    end
                end
            end
            default: begin
                if (start) begin
                    if (free_ok) begin
                        wr_en            = 1'b1;
                        wr_bank          = free_sel;
                        wr_addr          = '0;
                        wp_n             = ONE;
                        wb_n             = free_sel;
                        bank_n[free_sel] = B_FILLING;
                        state_n          = FILL;
                    end else begin
                        ovf_set = 1'b1;
                        state_n = DROP;
                    end
                end
            end
        endcase

        nxt_valid = (bank_n[ob_n] == B_FULL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            bank_st[0]    <= B_EMPTY;
            bank_st[1]    <= B_EMPTY;
            wp            <= '0;
            rp            <= '0;
            wb            <= 1'b0;
            ob            <= 1'b0;
            overflow      <= 1'b0;
            frame_err     <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_index <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            state         <= state_n;
            bank_st[0]    <= bank_n[0];
            bank_st[1]    <= bank_n[1];
            wp            <= wp_n;
            rp            <= rp_n;
            wb            <= wb_n;
            ob            <= ob_n;
            overflow      <= overflow | ovf_set;
            frame_err     <= frame_err | ferr_set;
            bus.out_valid <= nxt_valid;
            bus.out_data  <= nxt_valid ? mem[ob_n][rp_n] : '0;
            bus.out_index <= rp_n;
            bus.out_last  <= nxt_valid && (rp_n == LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end
endmodule
